spi_cmd_arbiter: RTL

- Packet-level arbiter and scheduler in front of the 5-wire SPI readout controller's command byte FIFO (ftdi_top/rfg SPI write FIFO, written in the fast domain).
- Shares that FIFO between two requesters:
  - host command stream from the FTDI register path;
  - internal auto-readout engine, triggered by chip interrupt (interruptB low) or a poll timer.
- An auto packet is one header byte followed by read_len IDLE bytes (0xBC). The SPI controller clocks these out to pull hit data on MISO.

---
 rtl/spi_cmd_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_arbiter.sv
// Round-robin packet arbiter sharing the SPI write FIFO between host command bytes and auto-readout packets.
// Grant costs one IDLE cycle; fifo_full stalls any state with state and length held, nothing lost or duplicated.
module spi_cmd_arbiter #(
  parameter logic [7:0]  AUTO_CMD    = 8'h00,
  parameter logic [7:0]  IDLE_BYTE   = 8'hBC,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        auto_enable,
  input  logic [15:0] poll_period,
  input  logic [7:0]  read_len,
  input  logic [7:0]  host_data,
  input  logic        host_valid,
  input  logic        host_last,
  output logic        host_ready,
  input  logic        interruptB,
  output logic [7:0]  fifo_data,
  output logic        fifo_wr_en,
  input  logic        fifo_full,
  output logic        busy,
  output logic        grant_host,
  output logic        grant_auto,
  output logic [15:0] auto_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOST_XFER = 2'd1,
    AUTO_HDR  = 2'd2,
    AUTO_FILL = 2'd3
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   intb_s;
  logic                   pending_q, pending_d;
  logic [15:0]            poll_q, poll_d;
  logic                   poll_expire;
  logic                   last_auto_q;
  logic [7:0]             len_q;
  logic [15:0]            auto_count_q;
  logic                   busy_q, grant_host_q, grant_auto_q;
  logic                   arb_open, gnt_host, gnt_auto;
  logic                   in_auto;

  always_ff @(posedge clock) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], interruptB};
  end

  assign intb_s  = sync_q[SYNC_STAGES-1];
  assign in_auto = (state_q == AUTO_HDR) || (state_q == AUTO_FILL);

  // On a tie the requester that did not win last time gets the bus.
  assign arb_open = (state_q == IDLE) && enable;
  assign gnt_host = arb_open && host_valid && (!pending_q || last_auto_q);
  assign gnt_auto = arb_open && pending_q && (!host_valid || !last_auto_q);

  // >= guards against poll_period being lowered below the running count.
  assign poll_expire = auto_enable && (poll_period != 16'd0) &&
                       (poll_q >= poll_period - 16'd1);

  // Counter is held at zero for the whole auto packet so the next poll is spaced from its end.
  always_comb begin
    poll_d = poll_q + 16'd1;
    if (!auto_enable || (poll_period == 16'd0) || gnt_auto || in_auto || poll_expire)
      poll_d = 16'd0;
  end

  always_comb begin
    pending_d = pending_q;
    if (!intb_s || poll_expire) pending_d = 1'b1;
    if (gnt_auto)               pending_d = 1'b0;
    if (!auto_enable)           pending_d = 1'b0;
  end

  always_comb begin
    host_ready = 1'b0;
    fifo_wr_en = 1'b0;
    fifo_data  = 8'h00;
    case (state_q)
      HOST_XFER: begin
        host_ready = !fifo_full;
        fifo_wr_en = host_valid && !fifo_full;
        fifo_data  = host_data;
      end
      AUTO_HDR: begin
        fifo_wr_en = !fifo_full;
        fifo_data  = AUTO_CMD;
      end
      AUTO_FILL: begin
        fifo_wr_en = !fifo_full;
        fifo_data  = IDLE_BYTE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      poll_q       <= 16'd0;
      last_auto_q  <= 1'b1;
      len_q        <= 8'd0;
      auto_count_q <= 16'd0;
      busy_q       <= 1'b0;
      grant_host_q <= 1'b0;
      grant_auto_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      poll_q    <= poll_d;
      case (state_q)
        IDLE: begin
          if (gnt_host) begin
            state_q      <= HOST_XFER;
            last_auto_q  <= 1'b0;
            busy_q       <= 1'b1;
            grant_host_q <= 1'b1;
          end else if (gnt_auto) begin
            state_q      <= AUTO_HDR;
            len_q        <= read_len;
            last_auto_q  <= 1'b1;
            busy_q       <= 1'b1;
            grant_auto_q <= 1'b1;
          end
        end
        HOST_XFER: begin
          if (host_valid && !fifo_full && host_last) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            grant_host_q <= 1'b0;
          end
        end
        AUTO_HDR: begin
          if (!fifo_full) begin
            if (len_q == 8'd0) begin
              state_q      <= IDLE;
              busy_q       <= 1'b0;
              grant_auto_q <= 1'b0;
              auto_count_q <= auto_count_q + 16'd1;
            end else begin
              state_q <= AUTO_FILL;
            end
          end
        end
        AUTO_FILL: begin
          if (!fifo_full) begin
            len_q <= len_q - 8'd1;
            if (len_q == 8'd1) begin
              state_q      <= IDLE;
              busy_q       <= 1'b0;
              grant_auto_q <= 1'b0;
              auto_count_q <= auto_count_q + 16'd1;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          grant_host_q <= 1'b0;
          grant_auto_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign grant_host = grant_host_q;
  assign grant_auto = grant_auto_q;
  assign auto_count = auto_count_q;

endmodule
